// File: rtl/kyber_pkg.sv
// Shared Kyber constants, FSM state type and modular arithmetic helpers
// used by both the forward and the inverse transform engines.
package kyber_pkg;

  localparam int N     = 256;
  localparam int Q     = 3329;
  localparam int N_INV = 3303;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    OUT     = 2'd3
  } intt_state_t;

  function automatic logic [11:0] mod_add(input logic [11:0] a, input logic [11:0] b,
                                          input logic [11:0] q);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) begin
      s = s - {1'b0, q};
    end else begin
      s = s;
    end
    return s[11:0];
  endfunction

  // Signed difference so a < b never wraps before the correction.
  function automatic logic [11:0] mod_sub(input logic [11:0] a, input logic [11:0] b,
                                          input logic [11:0] q);
    logic signed [13:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, b});
    if (d < 14'sd0) begin
      d = d + $signed({2'b00, q});
    end else begin
      d = d;
    end
    return d[11:0];
  endfunction

  function automatic logic [11:0] mod_mul(input logic [11:0] a, input logic [11:0] b,
                                          input logic [11:0] q);
    logic [23:0] p;
    logic [23:0] r;
    p = a * b;
    r = p % {12'd0, q};
    return r[11:0];
  endfunction

  // Folds any 16-bit signed coefficient into [0,q).
  function automatic logic [11:0] mod_reduce16(input logic signed [15:0] x,
                                               input logic [11:0] q);
    logic signed [16:0] xs;
    logic signed [16:0] qs;
    logic signed [16:0] r;
    xs = x;
    qs = $signed({5'd0, q});
    r  = xs % qs;
    if (r < 17'sd0) begin
      r = r + qs;
    end else begin
      r = r;
    end
    return r[11:0];
  endfunction

  // 17^BitRev7(idx) mod q, evaluated at elaboration time for the zeta table.
  function automatic int zeta_of(input int idx, input int q);
    int e;
    int z;
    int b;
    e = 0;
    for (int k = 0; k < 7; k++) begin
      if (((idx >> k) & 1) != 0) begin
        e = e | (1 << (6 - k));
      end else begin
        e = e;
      end
    end
    z = 1;
    b = 17;
    for (int k = 0; k < 7; k++) begin
      if (((e >> k) & 1) != 0) begin
        z = (z * b) % q;
      end else begin
        z = z;
      end
      b = (b * b) % q;
    end
    return z;
  endfunction

endpackage

// File: rtl/zeta_rom.sv
// Combinational twiddle-factor table: zeta[i] = 17^BitRev7(i) mod Q,
// the same table the forward transform walks upward from index 1.
module zeta_rom
  import kyber_pkg::*;
#(
  parameter int Q = kyber_pkg::Q
) (
  input  logic [6:0]  idx,
  output logic [11:0] zeta
);

  logic [11:0] rom_s [128];

  for (genvar g = 0; g < 128; g++) begin : g_rom
    localparam int ZV = zeta_of(g, Q);
    assign rom_s[g] = 12'(ZV);
  end

  assign zeta = rom_s[idx];

endmodule

// File: rtl/intt_engine.sv
// Streaming Kyber inverse NTT: loads 256 coefficients, runs the 7 Gentleman-Sande
// layers in place at one butterfly per cycle, then streams out f[k]*N_INV mod Q.
module intt_engine
  import kyber_pkg::*;
#(
  parameter int N     = kyber_pkg::N,
  parameter int Q     = kyber_pkg::Q,
  parameter int N_INV = kyber_pkg::N_INV
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_coef,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_coef,
  output logic               busy
);

  localparam int          AW       = $clog2(N);
  localparam int          LAYERS   = AW - 1;
  localparam logic [11:0] Q12      = 12'(Q);
  localparam logic [11:0] NINV12   = 12'(N_INV);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [AW-1:0] LEN0     = AW'(2);
  localparam logic [2:0]  LAST_LAYER = 3'(LAYERS - 1);

  intt_state_t      state_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [15:0]      out_coef_r;
  logic [AW-1:0]    idx_r;
  logic [2:0]       layer_r;
  logic [AW-1:0]    len_r;
  logic [AW-1:0]    start_r;
  logic [AW-1:0]    j_r;
  logic [6:0]       zidx_r;

  logic [11:0]      buf_r [N];

  logic [AW-1:0]    jl_s;
  logic [11:0]      a_s;
  logic [11:0]      b_s;
  logic [11:0]      zeta_s;
  logic [11:0]      sum_s;
  logic [11:0]      diff_s;
  logic [11:0]      prod_s;
  logic [AW:0]      next_start_s;
  logic             blk_end_s;
  logic             layer_end_s;
  logic             compute_done_s;
  logic [AW-1:0]    rd_idx_s;
  logic [11:0]      scale_s;
  logic [11:0]      ld_coef_s;
  logic             ld_we_s;
  logic             bf_we_s;

  zeta_rom #(.Q(Q)) u_zeta_rom (
    .idx  (zidx_r),
    .zeta (zeta_s)
  );

  // Butterfly datapath, loop-bound detection and output scaling.
  always_comb begin
    jl_s           = j_r + len_r;
    a_s            = buf_r[j_r];
    b_s            = buf_r[jl_s];
    sum_s          = mod_add(a_s, b_s, Q12);
    diff_s         = mod_sub(b_s, a_s, Q12);
    prod_s         = mod_mul(zeta_s, diff_s, Q12);
    next_start_s   = {1'b0, start_r} + {len_r, 1'b0};
    blk_end_s      = (({1'b0, j_r} + (AW+1)'(1)) == ({1'b0, start_r} + {1'b0, len_r}));
    layer_end_s    = blk_end_s && (next_start_s == (AW+1)'(N));
    compute_done_s = layer_end_s && (layer_r == LAST_LAYER);
    // Once a beat is showing, the next value to register is one index ahead.
    if (out_valid_r) begin
      rd_idx_s = idx_r + AW'(1);
    end else begin
      rd_idx_s = idx_r;
    end
    scale_s   = mod_mul(buf_r[rd_idx_s], NINV12, Q12);
    ld_coef_s = mod_reduce16(in_coef, Q12);
    ld_we_s   = !rst && (state_r == LOAD) && in_valid && in_ready_r;
    bf_we_s   = !rst && (state_r == COMPUTE);
  end

  // Coefficient buffer: written by load beats and by in-place butterflies, never reset.
  always_ff @(posedge clk) begin
    if (ld_we_s) begin
      buf_r[idx_r] <= ld_coef_s;
    end else if (bf_we_s) begin
      buf_r[j_r]  <= sum_s;
      buf_r[jl_s] <= prod_s;
    end
  end

  // Control FSM with registered handshake outputs and loop indices.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_coef_r  <= 16'd0;
      idx_r       <= '0;
      layer_r     <= 3'd0;
      len_r       <= '0;
      start_r     <= '0;
      j_r         <= '0;
      zidx_r      <= 7'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r    <= LOAD;
          in_ready_r <= 1'b1;
          idx_r      <= '0;
        end
        LOAD: begin
          if (in_valid && in_ready_r) begin
            if (idx_r == LAST_IDX) begin
              state_r    <= COMPUTE;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b1;
              idx_r      <= '0;
              layer_r    <= 3'd0;
              len_r      <= LEN0;
              start_r    <= '0;
              j_r        <= '0;
              zidx_r     <= 7'd127;
            end else begin
              idx_r <= idx_r + AW'(1);
            end
          end
        end
        COMPUTE: begin
          if (compute_done_s) begin
            state_r <= OUT;
            layer_r <= 3'd0;
            len_r   <= '0;
            start_r <= '0;
            j_r     <= '0;
            zidx_r  <= 7'd0;
          end else if (layer_end_s) begin
            layer_r <= layer_r + 3'd1;
            len_r   <= {len_r[AW-2:0], 1'b0};
            start_r <= '0;
            j_r     <= '0;
            zidx_r  <= zidx_r - 7'd1;
          end else if (blk_end_s) begin
            start_r <= next_start_s[AW-1:0];
            j_r     <= next_start_s[AW-1:0];
            zidx_r  <= zidx_r - 7'd1;
          end else begin
            j_r <= j_r + AW'(1);
          end
        end
        OUT: begin
          if (!out_valid_r) begin
            out_coef_r  <= {4'd0, scale_s};
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            if (idx_r == LAST_IDX) begin
              state_r     <= IDLE;
              out_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              idx_r       <= '0;
            end else begin
              idx_r      <= idx_r + AW'(1);
              out_coef_r <= {4'd0, scale_s};
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          idx_r       <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_coef  = out_coef_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_intt_engine.sv
// Directed bench for intt_engine with its own forward/inverse NTT reference model.
module tb_intt_engine;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_coef;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_coef;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int zt   [128];
  int vec  [256];
  int expv [256];
  logic signed [15:0] got [256];

  always #5 clk = ~clk;

  intt_engine #(.N(256), .Q(3329), .N_INV(3303)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int modq(input int x);
    return ((x % 3329) + 3329) % 3329;
  endfunction

  task automatic init_zetas();
    for (int i = 0; i < 128; i++) begin
      int e;
      int z;
      e = 0;
      for (int b = 0; b < 7; b++) if (((i >> b) & 1) != 0) e = e | (1 << (6 - b));
      z = 1;
      for (int m = 0; m < e; m++) z = (z * 17) % 3329;
      zt[i] = z;
    end
  endtask

  task automatic fwd_ntt();
    int i;
    i = 1;
    for (int len = 128; len >= 2; len = len / 2) begin
      for (int s = 0; s < 256; s = s + 2 * len) begin
        int z;
        z = zt[i];
        i++;
        for (int j = s; j < s + len; j++) begin
          int t;
          t = modq(z * vec[j + len]);
          vec[j + len] = modq(vec[j] - t);
          vec[j] = modq(vec[j] + t);
        end
      end
    end
  endtask

  task automatic inv_model();
    int i;
    for (int k = 0; k < 256; k++) expv[k] = modq(vec[k]);
    i = 127;
    for (int len = 2; len <= 128; len = len * 2) begin
      for (int s = 0; s < 256; s = s + 2 * len) begin
        int z;
        z = zt[i];
        i--;
        for (int j = s; j < s + len; j++) begin
          int t;
          t = expv[j];
          expv[j] = modq(t + expv[j + len]);
          expv[j + len] = modq(z * (expv[j + len] - t));
        end
      end
    end
    for (int k = 0; k < 256; k++) expv[k] = modq(expv[k] * 3303);
  endtask

  task automatic load_vec(input string tag);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, " in_ready"}, in_ready, 1);
    for (int k = 0; k < 256; k++) begin
      in_valid = 1'b1;
      in_coef  = 16'(vec[k]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_coef  = 16'sd0;
    check({tag, " in_ready drop"}, in_ready, 0);
    check({tag, " busy compute"}, busy, 1);
  endtask

  task automatic wait_first(input string tag, input bit chk_lat);
    int cnt;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, " out_valid rise"}, out_valid, 1);
    if (chk_lat) check({tag, " latency"}, cnt, 897);
  endtask

  task automatic unload(input string tag, input bit stall);
    int n;
    int cyc;
    bit was_stalled;
    logic signed [15:0] held;
    n = 0;
    cyc = 0;
    was_stalled = 1'b0;
    held = 16'sd0;
    while (n < 256 && cyc < 3000) begin
      if (was_stalled) check({tag, " hold"}, out_coef, held);
      out_ready = !(stall && (cyc % 3 == 2));
      was_stalled = 1'b0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          got[n] = out_coef;
          n++;
        end else begin
          held = out_coef;
          was_stalled = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check({tag, " beat count"}, n, 256);
    check({tag, " out_valid drop"}, out_valid, 0);
    check({tag, " busy drop"}, busy, 0);
    for (int k = 0; k < 256; k++) check($sformatf("%s[%0d]", tag, k), got[k], expv[k]);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_coef   = 16'sd0;
    out_ready = 1'b0;
    init_zetas();

    // Reset state
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset out_coef", out_coef, 0);
    rst = 1'b0;

    // All-zero transform with exact latency
    for (int k = 0; k < 256; k++) begin
      vec[k]  = 0;
      expv[k] = 0;
    end
    load_vec("zero");
    wait_first("zero", 1'b1);
    unload("zero", 1'b0);

    // Round trip: forward NTT of f[k]=k must come back as k
    for (int k = 0; k < 256; k++) vec[k] = k;
    fwd_ntt();
    for (int k = 0; k < 256; k++) expv[k] = k;
    load_vec("rt");
    wait_first("rt", 1'b1);
    unload("rt", 1'b0);

    // Same round trip with out_ready low every third cycle
    load_vec("bp");
    wait_first("bp", 1'b0);
    unload("bp", 1'b1);

    // Reset in the middle of COMPUTE, then a fresh random transform
    for (int k = 0; k < 256; k++) vec[k] = int'($urandom_range(0, 3328));
    load_vec("abort");
    repeat (400) @(negedge clk);
    check("abort busy before rst", busy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("abort in_ready", in_ready, 0);
    check("abort out_valid", out_valid, 0);
    check("abort busy", busy, 0);
    check("abort out_coef", out_coef, 0);
    rst = 1'b0;
    for (int k = 0; k < 256; k++) vec[k] = int'($urandom_range(0, 65535)) - 32768;
    inv_model();
    load_vec("rand");
    wait_first("rand", 1'b1);
    unload("rand", 1'b0);

    // Out-of-range inputs are folded into [0,Q)
    for (int k = 0; k < 256; k++) vec[k] = (k * 13) % 3329;
    vec[0] = -1;
    vec[1] = 3329;
    vec[2] = -3329;
    vec[3] = 32767;
    vec[4] = -32768;
    inv_model();
    load_vec("range");
    wait_first("range", 1'b1);
    unload("range", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intt_engine.md
INTT_ENGINE -- requirements
Module: intt_engine

Interface
REQ-001 SHALL have parameter N, default 256, meaning polynomial length (coefficients per transform).
REQ-002 SHALL have parameter Q, default 3329, meaning modulus.
REQ-003 SHALL have parameter N_INV, default 3303, meaning 128^-1 mod Q, the final scale factor.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  in_coef holds a valid NTT-domain coefficient.
REQ-007 SHALL have port in_ready  output  1  engine accepts a coefficient this cycle.
REQ-008 SHALL have port in_coef  input  16 signed  coefficient f_hat[k], delivered in order k=0..255.
REQ-009 SHALL have port out_valid  output  1  out_coef holds a valid result coefficient.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_coef this cycle.
REQ-011 SHALL have port out_coef  output  16 signed  result f[k] in [0,Q), emitted in order k=0..255.
REQ-012 SHALL have port busy  output  1  high in COMPUTE and OUT states.

Function
REQ-013 SHALL implement the FSM states IDLE, LOAD, COMPUTE, OUT.
REQ-014 IDLE SHALL move to LOAD on the next cycle; in_ready SHALL be high only in LOAD.
REQ-015 LOAD SHALL store one coefficient per in_valid&&in_ready beat into an N-entry buffer at the load index; each stored value SHALL be reduced to [0,Q), with negatives mapped by adding Q.
REQ-016 After beat 255, LOAD SHALL go to COMPUTE and in_ready SHALL drop on the following cycle.
REQ-017 COMPUTE SHALL run Gentleman-Sande layers for len=2,4,...,128, with start stepping by 2*len and j=start..start+len-1.
REQ-018 Each butterfly SHALL compute t=f[j]; f[j]=(t+f[j+len]) mod Q; f[j+len]=(zeta*(f[j+len]-t)) mod Q, with both results in [0,Q).
REQ-019 zeta SHALL be zetas[i], with i starting at 127 and decrementing once per start block; zetas[i]=17^BitRev7(i) mod Q.
REQ-020 COMPUTE SHALL retire one butterfly per cycle and SHALL last exactly 896 cycles (7 layers x 128 butterflies) before entering OUT.
REQ-021 OUT SHALL present out_coef=(f[k]*N_INV) mod Q with out_valid high.
REQ-022 In OUT, k SHALL advance only on out_valid&&out_ready; out_coef SHALL be held stable while out_ready is low.
REQ-023 After beat 255 is accepted, OUT SHALL return to IDLE and out_valid SHALL drop on the next cycle.
REQ-024 Products SHALL use at least 24 bits before reduction, and subtraction SHALL use signed arithmetic, so no intermediate overflows.
REQ-025 in_valid SHALL be ignored outside LOAD, and out_ready SHALL be ignored outside OUT.

Reset
REQ-026 rst SHALL take priority over all other inputs in every state, including mid-LOAD, mid-COMPUTE and mid-OUT.
REQ-027 On rst the FSM SHALL go to IDLE; in_ready, out_valid and busy SHALL be 0; out_coef SHALL be 0; all indices and the layer counter SHALL be 0.
REQ-028 Buffer contents SHALL NOT need a reset; a partial transform SHALL be discarded on rst.

Structure
REQ-029 N, Q, N_INV and the state enum SHALL live in shared package kyber_pkg.
REQ-030 The zeta table SHALL be implemented once in sub-module zeta_rom: a 7-bit index in, a 12-bit zeta out, combinational, with contents matching the forward-transform table.
REQ-031 Modular add, subtract and multiply SHALL be functions in kyber_pkg so they are shared with the forward transform.
REQ-032 The coefficient buffer SHALL be a single N x 12-bit array; no second buffer SHALL be used.

Verification
REQ-033 Reset: hold rst for 2 cycles -> in_ready=0, out_valid=0, busy=0, out_coef=0.
REQ-034 Zero input: load 256 zeros -> 256 outputs of 0; first out_valid exactly 897 cycles after the last load beat.
REQ-035 Round trip: f[k]=k -> forward NTT -> load into intt_engine -> outputs equal k for k=0..255.
REQ-036 Backpressure: same stimulus as REQ-035, with out_ready low on every third cycle -> identical sequence, no beat dropped or duplicated, out_coef stable while stalled.
REQ-037 Reset mid-COMPUTE: assert rst at COMPUTE cycle 400, then run a fresh transform of a random vector -> output matches the golden model.
REQ-038 Input range: load in_coef=-1 and in_coef=3329 -> stored as 3328 and 0; round-trip result matches the golden model.
